shift_register_ctrl: RTL and testbench

SHIFT_REGISTER_CTRL -- requirements
Module: shift_register_ctrl

---
 rtl/shift_register_ctrl.sv | 129 ++++++++++++
 tb/tb_shift_register_ctrl.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/shift_register_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : shift_register_ctrl
//  Brief    : Serialises a parallel word MSB-first into an external shift
//             register, then verifies the read-back contents.
//  Revision : 1.0 - initial release
// ============================================================================
module shift_register_ctrl #(
    parameter int WIDTH       = 8,
    parameter int CLEAR_FIRST = 1
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       load_valid,
    input  logic [WIDTH-1:0]           load_data,
    output logic                       load_ready,
    input  logic                       hold,
    input  logic                       abort,
    input  logic [WIDTH-1:0]           sr_stored_data,
    output logic                       sr_data,
    output logic                       sr_shift_enable,
    output logic                       sr_clear,
    output logic                       busy,
    output logic                       done,
    output logic                       match,
    output logic [$clog2(WIDTH+1)-1:0] bit_count
);

    localparam int               c_CNT_W = $clog2(WIDTH + 1);
    localparam logic [c_CNT_W-1:0] c_LAST  = c_CNT_W'(WIDTH - 1);
    localparam logic [c_CNT_W-1:0] c_ONE   = c_CNT_W'(1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_CLEAR = 2'd1,
        S_SHIFT = 2'd2,
        S_CHECK = 2'd3
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [WIDTH-1:0]     r_word;
    logic [WIDTH-1:0]     r_shreg;
    logic [c_CNT_W-1:0]   r_cnt;
    logic                 r_match;

    logic                 w_accept;
    logic                 w_shift;
    logic                 w_busy;
    logic                 w_eq;

    assign w_busy   = (r_state != S_IDLE);
    assign w_accept = (r_state == S_IDLE) && load_valid;
    assign w_shift  = (r_state == S_SHIFT) && !hold && !abort;
    assign w_eq     = (sr_stored_data == r_word);

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (load_valid) begin
                    w_state_nxt = (CLEAR_FIRST != 0) ? S_CLEAR : S_SHIFT;
                end
            end
            S_CLEAR: begin
                w_state_nxt = abort ? S_IDLE : S_SHIFT;
            end
            S_SHIFT: begin
                if (abort) begin
                    w_state_nxt = S_IDLE;
                end else if (!hold && (r_cnt == c_LAST)) begin
                    w_state_nxt = S_CHECK;
                end
            end
            S_CHECK: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Datapath: working copy shifts out MSB-first, r_word is kept for the check.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_word  <= '0;
            r_shreg <= '0;
            r_cnt   <= '0;
            r_match <= 1'b0;
        end else begin
            if (w_accept) begin
                r_word  <= load_data;
                r_shreg <= load_data;
                r_cnt   <= '0;
                r_match <= 1'b0;
            end else if (w_busy && abort) begin
                r_match <= 1'b0;
            end else if (w_shift) begin
                r_shreg <= r_shreg << 1;
                r_cnt   <= r_cnt + c_ONE;
            end else if (r_state == S_CHECK) begin
                r_match <= w_eq;
            end
        end
    end

    always_comb begin
        load_ready      = (r_state == S_IDLE);
        busy            = w_busy;
        sr_clear        = (r_state == S_CLEAR) || (w_busy && abort);
        sr_shift_enable = w_shift;
        sr_data         = (r_state == S_SHIFT) ? r_shreg[WIDTH-1] : 1'b0;
        done            = (r_state == S_CHECK) && !abort;
        // Read-back settles during CHECK, so match is shown live there and held after.
        match           = (r_state == S_CHECK) ? (!abort && w_eq) : r_match;
        bit_count       = r_cnt;
    end

endmodule
`default_nettype wire

// File: tb/tb_shift_register_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_shift_register_ctrl
//  Brief    : Directed bench with a transaction-level reference model for two
//             controller instances (CLEAR_FIRST = 1 and 0).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_shift_register_ctrl;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [1:0] lv = '0;
    logic [1:0] hd = '0;
    logic [1:0] ab = '0;
    logic [7:0] ld [2];
    bit   [7:0] srm [2];
    bit   [1:0] fault = '0;

    logic [1:0] lr, sd, se, sc, bz, dn, mt;
    logic [3:0] bc [2];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    shift_register_ctrl #(.WIDTH(8), .CLEAR_FIRST(1)) dut (
        .clk(clk), .reset_n(reset_n), .load_valid(lv[0]), .load_data(ld[0]),
        .load_ready(lr[0]), .hold(hd[0]), .abort(ab[0]), .sr_stored_data(srm[0]),
        .sr_data(sd[0]), .sr_shift_enable(se[0]), .sr_clear(sc[0]), .busy(bz[0]),
        .done(dn[0]), .match(mt[0]), .bit_count(bc[0])
    );

    shift_register_ctrl #(.WIDTH(8), .CLEAR_FIRST(0)) dut0 (
        .clk(clk), .reset_n(reset_n), .load_valid(lv[1]), .load_data(ld[1]),
        .load_ready(lr[1]), .hold(hd[1]), .abort(ab[1]), .sr_stored_data(srm[1]),
        .sr_data(sd[1]), .sr_shift_enable(se[1]), .sr_clear(sc[1]), .busy(bz[1]),
        .done(dn[1]), .match(mt[1]), .bit_count(bc[1])
    );

    task automatic chk(input string nm, input int i, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s inst%0d got %0h expected %0h at %0t", nm, i, act, exp, $time);
        end
    endtask

    // External shift register: shift left, serial data into LSB.
    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (fault[i])      srm[i] <= 8'h00;
            else if (sc[i])    srm[i] <= 8'h00;
            else if (se[i])    srm[i] <= {srm[i][6:0], sd[i]};
        end
    end

    // Reference model: a transfer is "bits sent so far" plus an optional clear phase.
    bit       m_busy  [2];
    bit       m_clr   [2];
    int       m_sent  [2];
    bit [7:0] m_word  [2];
    bit       m_match [2];

    always @(posedge clk or negedge reset_n) begin
        for (int i = 0; i < 2; i++) begin
            if (!reset_n) begin
                m_busy[i] <= 1'b0; m_clr[i] <= 1'b0; m_sent[i] <= 0;
                m_word[i] <= 8'h00; m_match[i] <= 1'b0;
            end else if (!m_busy[i]) begin
                if (lv[i]) begin
                    m_busy[i] <= 1'b1; m_word[i] <= ld[i]; m_sent[i] <= 0;
                    m_match[i] <= 1'b0; m_clr[i] <= (i == 0);
                end
            end else if (ab[i]) begin
                m_busy[i] <= 1'b0; m_match[i] <= 1'b0;
            end else if (m_clr[i]) begin
                m_clr[i] <= 1'b0;
            end else if (m_sent[i] == 8) begin
                m_match[i] <= (srm[i] == m_word[i]); m_busy[i] <= 1'b0;
            end else if (!hd[i]) begin
                m_sent[i] <= m_sent[i] + 1;
            end
        end
    end

    always @(negedge clk) begin
        bit ckp, shp, e_mt;
        for (int i = 0; i < 2; i++) begin
            ckp  = m_busy[i] && (m_sent[i] == 8);
            shp  = m_busy[i] && !m_clr[i] && !ckp;
            e_mt = ckp ? (!ab[i] && (srm[i] == m_word[i])) : m_match[i];
            chk("cmp_ready", i, lr[i], !m_busy[i]);
            chk("cmp_busy",  i, bz[i], m_busy[i]);
            chk("cmp_clear", i, sc[i], m_busy[i] && (m_clr[i] || ab[i]));
            chk("cmp_shen",  i, se[i], shp && !hd[i] && !ab[i]);
            chk("cmp_data",  i, sd[i], shp ? 32'((m_word[i] >> (7 - m_sent[i])) & 8'd1) : 32'd0);
            chk("cmp_done",  i, dn[i], ckp && !ab[i]);
            chk("cmp_match", i, mt[i], e_mt);
            chk("cmp_count", i, bc[i], m_sent[i]);
        end
    end

    // Per-run observations
    logic [7:0] r_bits;
    int         r_nsh, r_nclr;
    int         r_dq [$];
    bit         r_mq [$];
    logic       r_clr_at_ab, r_lr_after_ab;

    function automatic int qd(input int k);
        return (r_dq.size() > k) ? r_dq[k] : -1;
    endfunction

    function automatic int qm(input int k);
        return (r_mq.size() > k) ? int'(r_mq[k]) : -1;
    endfunction

    // Runs nc cycles starting at cycle 0 (load offered); called one tick after a rising edge.
    task automatic run(input int i, input logic [7:0] d, input int nc, input int hs, input int hl,
                       input int ac, input int c2, input logic [7:0] d2);
        r_bits = '0; r_nsh = 0; r_nclr = 0; r_dq.delete(); r_mq.delete();
        r_clr_at_ab = 1'bx; r_lr_after_ab = 1'bx;
        for (int c = 0; c < nc; c++) begin
            lv[i] = (c == 0) || (c == c2);
            ld[i] = (c2 > 0 && c >= c2) ? d2 : d;
            hd[i] = (c >= hs) && (c < hs + hl);
            ab[i] = (c == ac);
            @(negedge clk);
            if (se[i]) begin r_bits = {r_bits[6:0], sd[i]}; r_nsh++; end
            if (sc[i]) r_nclr++;
            if (c == ac) r_clr_at_ab = sc[i];
            if (c == ac + 1) r_lr_after_ab = lr[i];
            if (dn[i]) begin r_dq.push_back(c); r_mq.push_back(mt[i]); end
            @(posedge clk); #1;
        end
        lv[i] = 1'b0; hd[i] = 1'b0; ab[i] = 1'b0;
    endtask

    initial begin
        ld[0] = 8'h00; ld[1] = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ready", 0, lr[0], 1);
        chk("rst_busy",  0, bz[0], 0);
        chk("rst_count", 0, bc[0], 0);
        reset_n = 1'b1;
        @(posedge clk); #1;

        run(0, 8'hA5, 12, 1000, 0, -1, -1, 8'h00);
        chk("a5_bits",    0, r_bits, 8'hA5);
        chk("a5_nshift",  0, r_nsh, 8);
        chk("a5_ndone",   0, r_dq.size(), 1);
        chk("a5_done_at", 0, qd(0), 10);
        chk("a5_match",   0, qm(0), 1);
        chk("a5_srm",     0, srm[0], 8'hA5);

        run(0, 8'h96, 12, 0, 2, -1, -1, 8'h00);
        chk("holdidle_done_at", 0, qd(0), 10);
        chk("holdidle_bits",    0, r_bits, 8'h96);

        run(0, 8'h81, 15, 6, 3, -1, -1, 8'h00);
        chk("h81_nshift",  0, r_nsh, 8);
        chk("h81_bits",    0, r_bits, 8'h81);
        chk("h81_done_at", 0, qd(0), 13);
        chk("h81_match",   0, qm(0), 1);

        fault[0] = 1'b1;
        run(0, 8'hFF, 12, 1000, 0, -1, -1, 8'h00);
        fault[0] = 1'b0;
        chk("fault_done_at", 0, qd(0), 10);
        chk("fault_match",   0, qm(0), 0);

        run(0, 8'h3C, 8, 1000, 0, 5, -1, 8'h00);
        chk("abort_clear", 0, r_clr_at_ab, 1);
        chk("abort_ready", 0, r_lr_after_ab, 1);
        chk("abort_ndone", 0, r_dq.size(), 0);

        run(0, 8'h3C, 4, 1000, 0, -1, -1, 8'h00);
        #2 reset_n = 1'b0;
        #1;
        chk("mrst_ready", 0, lr[0], 1);
        chk("mrst_busy",  0, bz[0], 0);
        chk("mrst_done",  0, dn[0], 0);
        chk("mrst_match", 0, mt[0], 0);
        chk("mrst_data",  0, sd[0], 0);
        chk("mrst_shen",  0, se[0], 0);
        chk("mrst_clear", 0, sc[0], 0);
        chk("mrst_count", 0, bc[0], 0);
        @(posedge clk); #1;
        reset_n = 1'b1;
        run(0, 8'h5A, 12, 1000, 0, -1, -1, 8'h00);
        chk("post_rst_done_at", 0, qd(0), 10);
        chk("post_rst_match",   0, qm(0), 1);

        run(1, 8'h01, 21, 1000, 0, -1, 10, 8'h02);
        chk("b2b_ndone",  1, r_dq.size(), 2);
        chk("b2b_done0",  1, qd(0), 9);
        chk("b2b_done1",  1, qd(1), 19);
        chk("b2b_match0", 1, qm(0), 1);
        chk("b2b_match1", 1, qm(1), 1);
        chk("b2b_nclear", 1, r_nclr, 0);
        chk("b2b_srm",    1, srm[1], 8'h02);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
